// File: rtl/aligner.sv
// Word-alignment sequencer for the SDI receive path.
// On loss of alignment it issues one shift request, lets the datapath settle,
// resets the timing detector and then ignores the detector for a hold-off
// window before it will act again. The detector is also reset after sys_rst.
module aligner #(
  parameter int ALIGN_CYCLES   = 1,
  parameter int SETTLE_CYCLES  = 4,
  parameter int DET_RST_CYCLES = 4,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic n_align_i,
  output logic align_o,
  output logic detector_rst_o
);

  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_SLIP    = 3'd2;
  localparam logic [2:0] ST_SETTLE  = 3'd3;
  localparam logic [2:0] ST_DRST    = 3'd4;
  localparam logic [2:0] ST_HOLDOFF = 3'd5;

  // Each timed state loads N-1 on entry and leaves on the edge where the
  // counter reads zero, so it lasts exactly N clocks.
  localparam logic [15:0] ALIGN_LD   = 16'(ALIGN_CYCLES - 1);
  localparam logic [15:0] SETTLE_LD  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] DRST_LD    = 16'(DET_RST_CYCLES - 1);
  localparam logic [15:0] HOLDOFF_LD = 16'(HOLDOFF_CYCLES - 1);

  logic        n_align_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        align_q, align_d;
  logic        det_rst_q, det_rst_d;
  logic        cnt_done;

  assign cnt_done = (cnt_q == 16'd0);

  // Next-state and counter logic; n_align is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_done) begin
          state_d = ST_HOLDOFF;
          cnt_d   = HOLDOFF_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_IDLE: begin
        if (n_align_q) begin
          state_d = ST_SLIP;
          cnt_d   = ALIGN_LD;
        end
      end
      ST_SLIP: begin
        if (cnt_done) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_done) begin
          state_d = ST_DRST;
          cnt_d   = DRST_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DRST: begin
        if (cnt_done) begin
          state_d = ST_HOLDOFF;
          cnt_d   = HOLDOFF_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_done) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = DRST_LD;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registers change together
  // with the state and never overlap.
  always_comb begin
    align_d   = (state_d == ST_SLIP);
    det_rst_d = (state_d == ST_INIT) || (state_d == ST_DRST);
  end

  // State, counter, input sample and output registers; reset aborts any
  // sequence and holds the detector in reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      n_align_q <= 1'b0;
      state_q   <= ST_INIT;
      cnt_q     <= DRST_LD;
      align_q   <= 1'b0;
      det_rst_q <= 1'b1;
    end else begin
      n_align_q <= n_align_i;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      align_q   <= align_d;
      det_rst_q <= det_rst_d;
    end
  end

  assign align_o        = align_q;
  assign detector_rst_o = det_rst_q;

endmodule

// File: tb/tb_aligner.sv
// Directed bench for aligner: default-parameter instance plus a second
// instance with short timings (3/1/2/5, period 12).
module tb_aligner;

  logic sys_clk;
  logic rst, n_al, align, det;
  logic rst2, n_al2, align2, det2;
  int   checks;
  int   errors;

  aligner dut (
    .sys_clk        (sys_clk),
    .sys_rst        (rst),
    .n_align_i      (n_al),
    .align_o        (align),
    .detector_rst_o (det)
  );

  aligner #(
    .ALIGN_CYCLES   (3),
    .SETTLE_CYCLES  (1),
    .DET_RST_CYCLES (2),
    .HOLDOFF_CYCLES (5)
  ) dut_p (
    .sys_clk        (sys_clk),
    .sys_rst        (rst2),
    .n_align_i      (n_al2),
    .align_o        (align2),
    .detector_rst_o (det2)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int j, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s j=%0d observed=%b expected=%b", tag, j, obs, exp);
    end
  endtask

  initial begin
    int o, k;
    logic ea, ed;
    checks = 0;
    errors = 0;
    rst   = 1'b0;
    n_al  = 1'b0;
    rst2  = 1'b0;
    n_al2 = 1'b0;
    #2;
    rst  = 1'b1;
    rst2 = 1'b1;
    #1;
    // Reset takes effect before any clock edge
    chk("rst_async_align", 0, align, 1'b0);
    chk("rst_async_det", 0, det, 1'b1);
    chk("rst_async_det_p", 0, det2, 1'b1);

    // Reset held for 100 clocks
    for (int j = 1; j <= 100; j++) begin
      tick();
      chk("rst_hold_align", j, align, 1'b0);
      chk("rst_hold_det", j, det, 1'b1);
    end

    // Release: detector reset for 4 more edges, then quiet
    rst = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      tick();
      chk("init_align", j, align, 1'b0);
      chk("init_det", j, det, (j < 4));
    end

    // Single event: 10 clocks high in IDLE gives one sequence
    n_al = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      tick();
      chk("single_align", j, align, (j == 2));
      chk("single_det", j, det, (j >= 7 && j <= 10));
      if (j == 10) n_al = 1'b0;
    end

    // Persistent misalignment: rises every 26 clocks starting at j=2
    n_al = 1'b1;
    for (int j = 1; j <= 230; j++) begin
      tick();
      ea = 1'b0;
      ed = 1'b0;
      if (j >= 2) begin
        o = (j - 2) % 26;
        k = (j - 2) / 26;
        if (k <= 7) begin
          ea = (o == 0);
          ed = (o >= 5 && o <= 8);
        end
      end
      chk("persist_align", j, align, ea);
      chk("persist_det", j, det, ed);
      if (j == 200) n_al = 1'b0;
    end

    // One-clock pulse in IDLE, then a one-clock pulse inside HOLDOFF
    n_al = 1'b1;
    for (int j = 1; j <= 50; j++) begin
      tick();
      chk("ignore_align", j, align, (j == 2));
      chk("ignore_det", j, det, (j >= 7 && j <= 10));
      if (j == 1) n_al = 1'b0;
      if (j == 14) n_al = 1'b1;
      if (j == 15) n_al = 1'b0;
    end

    // Reset while align_o is high aborts immediately
    n_al = 1'b1;
    tick();
    tick();
    chk("midrst_pre_align", 0, align, 1'b1);
    n_al = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_async_align", 0, align, 1'b0);
    chk("midrst_async_det", 0, det, 1'b1);
    for (int j = 1; j <= 3; j++) begin
      tick();
      chk("midrst_hold_det", j, det, 1'b1);
    end
    rst  = 1'b0;
    n_al = 1'b1;
    for (int j = 1; j <= 25; j++) begin
      tick();
      chk("midrst_init_align", j, align, (j == 21));
      chk("midrst_init_det", j, det, (j < 4));
    end
    n_al = 1'b0;

    // Short-timing instance: INIT 2, HOLDOFF 5, then period 12 from j=8
    chk("sweep_rst_det", 0, det2, 1'b1);
    chk("sweep_rst_align", 0, align2, 1'b0);
    rst2  = 1'b0;
    n_al2 = 1'b1;
    for (int j = 1; j <= 60; j++) begin
      tick();
      ea = 1'b0;
      ed = (j == 1);
      if (j >= 8) begin
        o  = (j - 8) % 12;
        ea = (o < 3);
        ed = (o == 4 || o == 5);
      end
      chk("sweep_align", j, align2, ea);
      chk("sweep_det", j, det2, ed);
    end
    n_al2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
